// File: rtl/reg_dump_reader.sv
// reg_dump_reader: walks a circular range of register-file indices and
// presents each word, with its index, on a valid/ready stream. It keeps a
// running wrap-around sum of the words the consumer accepts.
module reg_dump_reader #(
  parameter int unsigned DATA_WIDTH = 32
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  start,
  input  logic [4:0]            first_reg,
  input  logic [4:0]            last_reg,
  output logic [4:0]            rf_addr,
  input  logic [DATA_WIDTH-1:0] rf_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [4:0]            out_index,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic                  busy,
  output logic                  done,
  output logic [DATA_WIDTH-1:0] checksum
);

  localparam int unsigned IDX_W = 5;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_LOAD,
    ST_SEND,
    ST_DONE
  } state_t;

  state_t           state;
  logic [IDX_W-1:0] index;
  logic [IDX_W-1:0] last_idx;

  // The register file is always addressed by the index being dumped.
  assign rf_addr = index;

  // Dump sequencer: captures the range, samples one word per LOAD, holds it
  // through SEND until accepted, and accumulates accepted words.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state     <= ST_IDLE;
      index     <= '0;
      last_idx  <= '0;
      out_valid <= 1'b0;
      out_index <= '0;
      out_data  <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      checksum  <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          done <= 1'b0;
          if (start) begin
            index    <= first_reg;
            last_idx <= last_reg;
            checksum <= '0;
            busy     <= 1'b1;
            state    <= ST_LOAD;
          end
        end
        ST_LOAD: begin
          out_data  <= rf_data;
          out_index <= index;
          out_valid <= 1'b1;
          state     <= ST_SEND;
        end
        ST_SEND: begin
          if (out_ready) begin
            checksum  <= checksum + out_data;
            out_valid <= 1'b0;
            if (index == last_idx) begin
              busy  <= 1'b0;
              done  <= 1'b1;
              state <= ST_DONE;
            end else begin
              index <= index + IDX_W'(1);
              state <= ST_LOAD;
            end
          end
        end
        ST_DONE: begin
          done  <= 1'b0;
          state <= ST_IDLE;
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule
